// File: rtl/brnch_recv_queue_pkg.sv
// Shared constants and helpers for the branch recovery queue.
package brnch_recv_queue_pkg;

  localparam int BRQ_DEPTH = 8;
  localparam int BRQ_PTR_W = 3;
  localparam int ADDR_W    = 16;

  typedef logic [BRQ_PTR_W-1:0] brq_tag_t;

  // Program-order distance of a tag from the head; larger means younger.
  function automatic brq_tag_t brq_age(input brq_tag_t tag, input brq_tag_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/brq_entry_array.sv
// Recovery-PC storage: two write ports (one per allocation slot), one async read port.
module brq_entry_array #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we0,
  input  logic [PTR_W-1:0]  waddr0,
  input  logic [ADDR_W-1:0] wdata0,
  input  logic              we1,
  input  logic [PTR_W-1:0]  waddr1,
  input  logic [ADDR_W-1:0] wdata1,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/brnch_recv_queue.sv
// Branch recovery queue: tracks in-flight predicted branches in program order,
// retires correct ones from the head and redirects fetch on a mispredict.
module brnch_recv_queue #(
  parameter int DEPTH  = brnch_recv_queue_pkg::BRQ_DEPTH,
  parameter int PTR_W  = brnch_recv_queue_pkg::BRQ_PTR_W,
  parameter int ADDR_W = brnch_recv_queue_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_vld0,
  input  logic              alloc_vld1,
  input  logic [ADDR_W-1:0] recv_pc0,
  input  logic [ADDR_W-1:0] recv_pc1,
  output logic              alloc_rdy,
  output logic [PTR_W-1:0]  alloc_tag0,
  output logic [PTR_W-1:0]  alloc_tag1,
  input  logic              resolve_vld,
  input  logic [PTR_W-1:0]  resolve_tag,
  input  logic              resolve_mispred,
  output logic              flush_vld,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);

  import brnch_recv_queue_pkg::*;

  logic [DEPTH-1:0]  valid_q, done_q, valid_nxt, done_nxt, squash_mask;
  logic [PTR_W-1:0]  head_q, tail_q, tail_nxt;
  logic [PTR_W:0]    count_q, count_nxt, n_alloc, n_squash;
  logic [PTR_W+1:0]  count_add, count_sub;
  logic              count_ok;
  logic              flush_vld_q;
  logic [ADDR_W-1:0] flush_pc_q, rd_pc;
  logic              resolve_hit, mispred, retire, do_alloc0, do_alloc1;

  assign resolve_hit = resolve_vld && valid_q[resolve_tag];
  assign mispred     = resolve_hit && resolve_mispred;
  assign retire      = valid_q[head_q] && done_q[head_q];

  // Any mispredict on the resolve port blocks allocation, even a stale one.
  assign alloc_rdy  = (count_q <= (PTR_W+1)'(DEPTH - 2)) && !(resolve_vld && resolve_mispred);
  assign alloc_tag0 = tail_q;
  assign alloc_tag1 = tail_q + PTR_W'(1);
  assign do_alloc0  = alloc_rdy && alloc_vld0;
  assign do_alloc1  = do_alloc0 && alloc_vld1;
  assign n_alloc    = {{PTR_W{1'b0}}, do_alloc0} + {{PTR_W{1'b0}}, do_alloc1};

  // Squash every live entry younger than the mispredicted one.
  always_comb begin
    squash_mask = '0;
    n_squash    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mispred && valid_q[i] &&
          (brq_age(brq_tag_t'(i), head_q) > brq_age(resolve_tag, head_q)))
        squash_mask[i] = 1'b1;
      n_squash = n_squash + {{PTR_W{1'b0}}, squash_mask[i]};
    end
  end

  always_comb begin
    valid_nxt = valid_q & ~squash_mask;
    done_nxt  = done_q;
    if (resolve_hit) done_nxt[resolve_tag] = 1'b1;
    if (retire)      valid_nxt[head_q] = 1'b0;
    if (do_alloc0) begin
      valid_nxt[alloc_tag0] = 1'b1;
      done_nxt[alloc_tag0]  = 1'b0;
    end
    if (do_alloc1) begin
      valid_nxt[alloc_tag1] = 1'b1;
      done_nxt[alloc_tag1]  = 1'b0;
    end
  end

  assign tail_nxt  = mispred ? (resolve_tag + PTR_W'(1)) : (tail_q + n_alloc[PTR_W-1:0]);
  assign count_nxt = count_q + n_alloc - {{PTR_W{1'b0}}, retire} - n_squash;
  assign count_add = {1'b0, count_q} + {1'b0, n_alloc};
  assign count_sub = {1'b0, {PTR_W{1'b0}}, retire} + {1'b0, n_squash};
  assign count_ok  = (count_add >= count_sub) &&
                     ((count_add - count_sub) <= (PTR_W+2)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_vld_q <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      assert (count_ok);
      valid_q     <= valid_nxt;
      done_q      <= done_nxt;
      head_q      <= head_q + {{(PTR_W-1){1'b0}}, retire};
      tail_q      <= tail_nxt;
      count_q     <= count_nxt;
      flush_vld_q <= mispred;
      if (mispred) flush_pc_q <= rd_pc;
    end
  end

  brq_entry_array #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .ADDR_W (ADDR_W)
  ) u_entry_array (
    .clk    (clk),
    .we0    (do_alloc0),
    .waddr0 (alloc_tag0),
    .wdata0 (recv_pc0),
    .we1    (do_alloc1),
    .waddr1 (alloc_tag1),
    .wdata1 (recv_pc1),
    .raddr  (resolve_tag),
    .rdata  (rd_pc)
  );

  assign flush_vld = flush_vld_q;
  assign flush_pc  = flush_pc_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: doc/brnch_recv_queue.md
Name: brnch_recv_queue

Overview:
- Downstream of the branch address calculator. Holds the recovery PC of every in-flight predicted branch, in program order, and returns a tag per branch.
- When execute resolves a branch as mispredicted, the block emits that branch's recovery PC to fetch for one cycle. It also squashes all younger entries.
- Correctly predicted branches are retired from the head in order.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PTR_W, 3, log2(DEPTH); tag and pointer width.
- ADDR_W, 16, PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_vld0  in  1  allocate an entry for the older branch of this fetch group.
- alloc_vld1  in  1  allocate an entry for the younger branch; ignored unless alloc_vld0=1.
- recv_pc0  in  ADDR_W  recovery PC for the alloc0 branch.
- recv_pc1  in  ADDR_W  recovery PC for the alloc1 branch.
- alloc_rdy  out  1  queue can accept two allocations this cycle.
- alloc_tag0  out  PTR_W  tag given to alloc0; equals tail.
- alloc_tag1  out  PTR_W  tag given to alloc1; equals (tail+1) mod DEPTH.
- resolve_vld  in  1  execute resolves one branch this cycle.
- resolve_tag  in  PTR_W  tag of the resolved branch.
- resolve_mispred  in  1  the resolved branch was mispredicted.
- flush_vld  out  1  registered one-cycle pulse: redirect fetch.
- flush_pc  out  ADDR_W  recovery PC; valid while flush_vld=1.
- count  out  PTR_W+1  number of valid entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset state: head=0, tail=0, count=0, all valid/done bits 0, flush_vld=0, flush_pc=0, empty=1, full=0, alloc_rdy=1. Reset mid-flush drops the pending pulse.
- Entry state: valid, done, recv_pc.
- alloc_rdy:
  - alloc_rdy = (DEPTH-count >= 2) && !(resolve_vld && resolve_mispred).
  - It is purely combinational from registered state and the resolve inputs.
  - Allocation while alloc_rdy=0 is dropped; upstream must hold its request.
- Allocation (alloc_rdy=1):
  - alloc_vld0 writes entry[tail]: valid=1, done=0, recv_pc0.
  - alloc_vld1 (with alloc_vld0) also writes entry[tail+1] with recv_pc1.
  - tail advances by 1 or 2 modulo DEPTH.
  - Tags are visible in the same cycle as the request.
- Resolve:
  - Resolve is ignored if the entry at resolve_tag has valid=0 (stale tag after a flush).
  - Correct prediction: set done=1 on the entry.
  - Mispredict:
    - Set done=1 on the entry.
    - Clear valid on every entry strictly younger than the tag (from tag+1 up to tail-1, modulo).
    - Set tail=(tag+1) mod DEPTH.
    - Next cycle: flush_vld=1 and flush_pc=that entry's recv_pc.
    - The cycle after that: flush_vld=0.
    - flush_pc holds its last value when flush_vld=0.
- Retire: each cycle, if entry[head] has valid=1 and done=1, clear valid and advance head by 1. At most one retire per cycle.
- count:
  - next = count + allocations − retire − squashed entries.
  - count must never underflow or exceed DEPTH; assert this in simulation.
- Simultaneous events:
  - Retire of head and a correct resolve of another tag in the same cycle are both applied.
  - Mispredict of the head entry in cycle N: the head entry is kept, all other entries are squashed, and the head retires in cycle N+1.
  - Alloc together with mispredict: the alloc is blocked by alloc_rdy=0.
  - Alloc in the flush_vld cycle is allowed.
- Wrap-around: head, tail and tags are modulo DEPTH. Full versus empty is distinguished by count only.
- Latency: alloc to visible count is 1 cycle; resolve to flush_vld is 1 cycle; done to retire is 1 cycle minimum.

Decomposition:
- Shared package constants: BRQ_DEPTH, BRQ_PTR_W, ADDR_W. Also a function brq_age(tag, head) that returns the program-order distance, used for younger-than compares.
- Sub-module brq_entry_array: register file of recv_pc with two write ports and one async read port (read for flush_pc).
- Pointer, count and squash-mask logic stay in the top level.

Test Plan:
- Reset with rst=1 for 2 cycles -> count=0, empty=1, alloc_rdy=1, flush_vld=0, alloc_tag0=0, alloc_tag1=1.
- Dual alloc: recv_pc0=16'h0011, recv_pc1=16'h0020 -> tags 0 and 1; next cycle count=2. Correct resolves of tags 0 then 1 -> retired on consecutive cycles, empty=1.
- Fill with 4 dual allocs -> count=8, full=1, alloc_rdy=0. A fifth dual request is dropped and tail is unchanged.
- Entries 0..5 valid; mispredict tag 2 (stored recv_pc=16'h1234) -> next cycle flush_vld=1, flush_pc=16'h1234, count=3, tail=3. A later resolve of tag 4 is ignored.
- Wrap: head=6, alloc at tail=7 -> tags 7 and 0. Mispredict tag 7 -> tail=0, entry 0 squashed.
- Mispredict the head entry with alloc_vld0=1 in the same cycle -> alloc dropped, head entry retires next cycle, count=0 two cycles later.
